// File: rtl/cgia_pkg.sv
// Shared constants and helpers for the pixel packing path.
// - WORD_W / PEN_W : packed word width and pen (pixel bus) width
// - DEPTH_*        : encoding of the 2-bit bits-per-pixel selector
// - pix_per_word() : number of pixels that fill one packed word
package cgia_pkg;

  localparam int WORD_W = 16;
  localparam int PEN_W  = 8;

  localparam logic [1:0] DEPTH_1BPP = 2'd0;
  localparam logic [1:0] DEPTH_2BPP = 2'd1;
  localparam logic [1:0] DEPTH_4BPP = 2'd2;
  localparam logic [1:0] DEPTH_8BPP = 2'd3;

  // 16 / (1 << depth): 16, 8, 4 or 2 pixels per word
  function automatic logic [4:0] pix_per_word(input logic [1:0] depth);
    return 5'd16 >> depth;
  endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out bus of the pixel packer.
// Both ports use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the source holds its payload and valid
// stable until that edge, and ready never depends combinationally on valid.
// - depth_i, color_i, pix_valid_i, flush_i, pix_ready_o : pixel side
// - dat_o, dat_valid_o, dat_ready_i                      : word side
// The slave modport is the packer; the master modport is its environment.
interface pixel_packer_if;
  import cgia_pkg::*;

  logic [1:0]        depth_i;
  logic [PEN_W-1:0]  color_i;
  logic              pix_valid_i;
  logic              pix_ready_o;
  logic              flush_i;
  logic [WORD_W-1:0] dat_o;
  logic              dat_valid_o;
  logic              dat_ready_i;

  modport slave (
    input  depth_i, color_i, pix_valid_i, flush_i, dat_ready_i,
    output pix_ready_o, dat_o, dat_valid_o
  );

  modport master (
    output depth_i, color_i, pix_valid_i, flush_i, dat_ready_i,
    input  pix_ready_o, dat_o, dat_valid_o
  );
endinterface

// File: rtl/word_outreg.sv
// Output holding register for packed words.
// - clk, rst     : clock, synchronous active-high reset
// - i_load       : capture i_word and present it (caller only loads when
//                  o_can_take is high)
// - i_word       : word to present
// - i_ready      : consumer takes o_dat this cycle
// - o_dat        : presented word (holds its last value after acceptance)
// - o_valid      : o_dat holds a word
// - o_can_take   : register is empty or is being emptied this cycle
module word_outreg
  import cgia_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_dat,
  output logic              o_valid,
  output logic              o_can_take
);

  logic [WORD_W-1:0] r_dat;
  logic              r_valid;

  assign o_can_take = ~r_valid | i_ready;
  assign o_dat      = r_dat;
  assign o_valid    = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_dat   <= i_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs pen values MSB-first into 16-bit words at 1, 2, 4 or 8 bpp.
// - dotclk_i : dot clock, all state changes on its rising edge
// - reset_i  : synchronous active-high reset, discards partial/pending words
// - bus      : pixel_packer_if.slave (pixel input, flush, word output)
// Holds up to two words: one in the output register, one parked in the
// accumulator (r_acc_full) while the output register is blocked.
module pixel_packer
  import cgia_pkg::*;
(
  input  logic          dotclk_i,
  input  logic          reset_i,
  pixel_packer_if.slave bus
);

  logic [WORD_W-1:0] r_acc;
  logic [4:0]        r_count;
  logic [1:0]        r_depth_q;
  logic              r_acc_full;
  logic              r_pix_ready;

  logic              w_pix_acc;
  logic [1:0]        w_depth;
  logic [4:0]        w_n;
  logic [4:0]        w_ppw;
  logic [WORD_W-1:0] w_mask;
  logic [WORD_W-1:0] w_acc_pix;
  logic [WORD_W-1:0] w_acc_next;
  logic [4:0]        w_cnt_next;
  logic              w_complete;
  logic              w_flush;
  logic              w_word_done;
  logic [4:0]        w_pad;
  logic [WORD_W-1:0] w_word;
  logic              w_can_take;
  logic              w_load;
  logic [WORD_W-1:0] w_load_word;

  assign w_pix_acc = bus.pix_valid_i & r_pix_ready;

  // The first pixel of a word uses the depth being latched on this edge.
  assign w_depth = (r_count == 5'd0) ? bus.depth_i : r_depth_q;
  assign w_n     = 5'd1 << w_depth;
  assign w_ppw   = pix_per_word(w_depth);

  always_comb begin
    w_mask = '0;
    case (w_depth)
      DEPTH_1BPP: w_mask = 16'h0001;
      DEPTH_2BPP: w_mask = 16'h0003;
      DEPTH_4BPP: w_mask = 16'h000F;
      DEPTH_8BPP: w_mask = 16'h00FF;
      default:    w_mask = '0;
    endcase
  end

  assign w_acc_pix  = (r_acc << w_n) |
                      ({{(WORD_W-PEN_W){1'b0}}, bus.color_i} & w_mask);
  assign w_acc_next = w_pix_acc ? w_acc_pix : r_acc;
  assign w_cnt_next = r_count + {4'd0, w_pix_acc};

  // A same-edge pixel is packed before the flush; if it fills the word the
  // flush has nothing left to do.
  assign w_complete  = w_pix_acc && (w_cnt_next == w_ppw);
  assign w_flush     = bus.flush_i && !r_acc_full && (w_cnt_next != 5'd0) &&
                       !w_complete;
  assign w_word_done = w_complete | w_flush;

  // Left-justify a partial word: pad the missing pixel slots with zeros.
  assign w_pad  = 5'((w_ppw - w_cnt_next) * w_n);
  assign w_word = w_complete ? w_acc_next : (w_acc_next << w_pad);

  // A parked word always drains before any new word can be produced,
  // because pixel input is stalled while r_acc_full is set.
  assign w_load      = w_can_take & (r_acc_full | w_word_done);
  assign w_load_word = r_acc_full ? r_acc : w_word;

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_depth_q   <= DEPTH_1BPP;
      r_acc_full  <= 1'b0;
      r_pix_ready <= 1'b1;
    end else begin
      if (w_pix_acc && (r_count == 5'd0)) begin
        r_depth_q <= bus.depth_i;
      end
      if (r_acc_full) begin
        if (w_can_take) begin
          r_acc_full  <= 1'b0;
          r_pix_ready <= 1'b1;
        end
      end else if (w_word_done) begin
        r_count <= '0;
        r_acc   <= w_word;
        if (!w_can_take) begin
          r_acc_full  <= 1'b1;
          r_pix_ready <= 1'b0;
        end
      end else if (w_pix_acc) begin
        r_acc   <= w_acc_pix;
        r_count <= w_cnt_next;
      end
    end
  end

  assign bus.pix_ready_o = r_pix_ready;

  word_outreg u_outreg (
    .clk        (dotclk_i),
    .rst        (reset_i),
    .i_load     (w_load),
    .i_word     (w_load_word),
    .i_ready    (bus.dat_ready_i),
    .o_dat      (bus.dat_o),
    .o_valid    (bus.dat_valid_o),
    .o_can_take (w_can_take)
  );

endmodule

// File: tb/tb_pixel_packer.sv
// Testbench for pixel_packer: scenario tasks with inline checks plus a word
// scoreboard fed by the stimulus and drained by an output monitor.
module tb_pixel_packer;
  import cgia_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_packer_if bus ();

  pixel_packer dut (
    .dotclk_i (clk),
    .reset_i  (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] mon_exp;
  bit rand_ready_en = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Random consumer backpressure, changed just after the active edge.
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      bus.dat_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.dat_valid_o && bus.dat_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %h, required no word", bus.dat_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.dat_o !== mon_exp) begin
          errors++;
          $display("FAIL word_data: got %h, required %h", bus.dat_o, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [PEN_W-1:0] c);
    int t;
    bit done;
    bus.color_i     = c;
    bus.pix_valid_i = 1'b1;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.pix_ready_o === 1'b1) begin
        done = 1'b1;
      end else begin
        stall_cycles++;
        t++;
        if (t > 200) begin
          checks++;
          errors++;
          $display("FAIL pix_ready_timeout: pix_ready_o %b for 200 cycles, required 1", bus.pix_ready_o);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pixels();
    bus.pix_valid_i = 1'b0;
    bus.color_i     = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.dat_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dat: got %h, required 0000", bus.dat_o);
    end
    checks++;
    if (bus.dat_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", bus.dat_valid_o);
    end
    checks++;
    if (bus.pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pix_ready: got %b, required 1", bus.pix_ready_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_1bpp_alternating();
    bus.depth_i = DEPTH_1BPP;
    exp_q.push_back(16'hAAAA);
    for (int i = 0; i < 16; i++) send_pixel((i % 2 == 0) ? 8'h01 : 8'h00);
    idle_pixels();
    @(negedge clk);
    checks++;
    if (bus.dat_valid_o !== 1'b1 || bus.dat_o !== 16'hAAAA) begin
      errors++;
      $display("FAIL latency_1bpp: valid %b dat %h, required valid 1 dat aaaa", bus.dat_valid_o, bus.dat_o);
    end
    @(negedge clk);
    checks++;
    if (bus.dat_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle_valid: got %b, required 0", bus.dat_valid_o);
    end
    wait_drain();
  endtask

  task automatic test_8bpp_and_mask();
    bus.depth_i = DEPTH_8BPP;
    exp_q.push_back(16'h1234);
    send_pixel(8'h12);
    send_pixel(8'h34);
    idle_pixels();
    wait_drain();
    bus.depth_i = DEPTH_1BPP;
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 16; i++) send_pixel(8'hFF);
    idle_pixels();
    wait_drain();
  endtask

  task automatic test_flush();
    int seen;
    bus.depth_i = DEPTH_4BPP;
    exp_q.push_back(16'h5670);
    send_pixel(8'h05);
    send_pixel(8'h06);
    send_pixel(8'h07);
    idle_pixels();
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    wait_drain();
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.dat_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL empty_flush: valid seen %0d cycles, required 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mode_latch();
    bus.depth_i = DEPTH_2BPP;
    exp_q.push_back(16'h6C6C);
    send_pixel(8'h01);
    bus.depth_i = DEPTH_8BPP;
    send_pixel(8'h02);
    send_pixel(8'h03);
    send_pixel(8'h00);
    send_pixel(8'h01);
    send_pixel(8'h02);
    send_pixel(8'h03);
    send_pixel(8'h00);
    idle_pixels();
    wait_drain();
    exp_q.push_back(16'hA55A);
    send_pixel(8'hA5);
    send_pixel(8'h5A);
    idle_pixels();
    wait_drain();
  endtask

  task automatic test_backpressure();
    int bad;
    bus.dat_ready_i = 1'b0;
    bus.depth_i = DEPTH_2BPP;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 16; i++) send_pixel({6'($urandom_range(0, 63)), 2'b11});
    bus.color_i = 8'h00;  // pixel offered while stalled must not be taken
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.dat_valid_o !== 1'b1 || bus.dat_o !== 16'hFFFF || bus.pix_ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d bad cycles (valid %b dat %h pix_ready %b), required 0", bad, bus.dat_valid_o, bus.dat_o, bus.pix_ready_o);
    end
    idle_pixels();
    @(posedge clk);
    #1;
    bus.dat_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dat_valid_o !== 1'b1 || bus.pix_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_first: valid %b pix_ready %b, required 1 0", bus.dat_valid_o, bus.pix_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.dat_valid_o !== 1'b1 || bus.dat_o !== 16'hFFFF || bus.pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_second: valid %b dat %h pix_ready %b, required 1 ffff 1", bus.dat_valid_o, bus.dat_o, bus.pix_ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.dat_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: valid %b, required 0", bus.dat_valid_o);
    end
    wait_drain();
  endtask

  task automatic test_reset_midword();
    bus.depth_i = DEPTH_8BPP;
    send_pixel(8'hAB);
    idle_pixels();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dat_o !== 16'h0000 || bus.dat_valid_o !== 1'b0 || bus.pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midword_reset: dat %h valid %b pix_ready %b, required 0000 0 1", bus.dat_o, bus.dat_valid_o, bus.pix_ready_o);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(16'hCDEF);
    send_pixel(8'hCD);
    send_pixel(8'hEF);
    idle_pixels();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int stalls_before;
    logic [7:0] a;
    logic [7:0] b;
    bus.depth_i = DEPTH_8BPP;
    stalls_before = stall_cycles;
    for (int w = 0; w < 4; w++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({a, b});
      send_pixel(a);
      send_pixel(b);
    end
    idle_pixels();
    checks++;
    if (stall_cycles != stalls_before) begin
      errors++;
      $display("FAIL back_to_back_stall: %0d stall cycles, required 0", stall_cycles - stalls_before);
    end
    wait_drain();
  endtask

  task automatic test_random();
    int d;
    int n;
    int ppw;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] mask;
    logic [PEN_W-1:0] c [16];
    rand_ready_en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      d = $urandom_range(0, 3);
      n = 1 << d;
      ppw = 16 / n;
      mask = 16'((1 << n) - 1);
      word = '0;
      for (int k = 0; k < ppw; k++) begin
        c[k] = 8'($urandom_range(0, 255));
        word = (word << n) | ({8'h00, c[k]} & mask);
      end
      exp_q.push_back(word);
      bus.depth_i = 2'(d);
      for (int k = 0; k < ppw; k++) begin
        send_pixel(c[k]);
        bus.depth_i = 2'($urandom_range(0, 3));
      end
    end
    idle_pixels();
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    bus.dat_ready_i = 1'b1;
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.depth_i     = DEPTH_1BPP;
    bus.color_i     = '0;
    bus.pix_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.dat_ready_i = 1'b1;
    test_reset();
    test_1bpp_alternating();
    test_8bpp_and_mask();
    test_flush();
    test_mode_latch();
    test_backpressure();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Inverse of the pixel shifter. It accepts one color pen value per accepted handshake and packs pixels MSB-first into 16-bit words at 1, 2, 4 or 8 bpp.
- Completed words go out on a valid/ready word port toward the frame-buffer write path (capture, readback and blitter-source paths).
- Bit packing mirrors the shifter exactly: the first pixel of a word occupies its most-significant N bits.

Parameters:
- None. Word width is fixed at 16 bits and pixel bus width at 8 bits.

Ports:
- dotclk_i  in  1  dot clock; all state changes on its rising edge
- reset_i  in  1  synchronous, active-high reset
- depth_i  in  2  bits per pixel: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp
- color_i  in  8  pixel value; only bits [N-1:0] are used
- pix_valid_i  in  1  color_i holds a pixel
- pix_ready_o  out  1  packer can accept a pixel this cycle (registered)
- flush_i  in  1  pad and emit the partial word
- dat_o  out  16  packed word
- dat_valid_o  out  1  dat_o holds a word
- dat_ready_i  in  1  consumer takes dat_o this cycle

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs, including mid-word): the following are cleared.
  - acc=0, count=0, depth_q=0, acc_full=0
  - dat_o=0000, dat_valid_o=0, pix_ready_o=1
  - Any partial or pending word is discarded.
- Definitions:
  - Pixel accept = pix_valid_i & pix_ready_o at an edge.
  - Word accept = dat_valid_o & dat_ready_i at an edge.
  - can_take = ~dat_valid_o | dat_ready_i.
- Depth latch: on a pixel accept with count==0, depth_q ← depth_i. depth_i changes mid-word are ignored until the next word starts.
- Pixel accept: acc ← (acc << N) | color_i[N-1:0], with N=1<<depth_q (using the freshly latched value on the first pixel). Then count ← count+1.
- Word completion occurs when count reaches 16/N, i.e. 16, 8, 4 or 2 pixels.
  - If can_take: dat_o ← word, dat_valid_o ← 1 on that same edge; count ← 0. Latency: dat_valid_o is high in the cycle after the last pixel accept.
  - Else: acc_full ← 1, count ← 0, pix_ready_o ← 0.
- acc_full drain: when acc_full & can_take, dat_o ← acc, dat_valid_o ← 1, acc_full ← 0, pix_ready_o ← 1. No pixel can be accepted in that cycle because pix_ready_o was low.
- Word accept with no replacement word: dat_valid_o ← 0. dat_o holds its last value.
- dat_o and dat_valid_o are stable while dat_valid_o=1 and dat_ready_i=0.
- Throughput: one pixel per clock with no bubbles while the consumer keeps dat_ready_i high. There is no combinational path from any input to any output.
- Flush:
  - flush_i with count>0: the partial word is left-justified, i.e. acc shifted left by (16/N − count)·N with zero fill. It then completes exactly as above.
  - Same-edge pixel accept: the pixel is packed first, then the flush applies.
  - If that pixel itself completes the word: normal completion, and the flush is a no-op.
  - flush_i with count==0, or with acc_full=1: no-op.
- Holding capacity: two words, one in the output register and one in the accumulator. After that, pix_ready_o stays low until a word accept.

Decomposition:
- Package cgia_pkg holds:
  - depth encoding constants DEPTH_1BPP..DEPTH_8BPP
  - function pix_per_word(depth) returning 16/8/4/2
  - WORD_W=16, PEN_W=8
- One natural sub-module: word_outreg, the output holding register with valid/ready and its can_take logic.
- Packing, count and flush logic stay in pixel_packer.

Test Plan:
- 1bpp, dat_ready_i=1: 16 pixels alternating 1,0,… → dat_o=AAAA, dat_valid_o=1 in the cycle after the 16th accept, for exactly one cycle.
- 8bpp: pixels 12,34 → dat_o=1234. With color_i=FF at 1bpp, each pixel contributes only a 1; 16 such pixels → FFFF.
- 4bpp: pixels 5,6,7 then flush_i → dat_o=5670. A second flush_i with no pixels produces no word.
- Mode latch: depth_i=1 at the first pixel, changed to 3 mid-word. Pixels 1,2,3,0,1,2,3,0 → 6C6C. The next word uses 8bpp.
- Backpressure: 2bpp, dat_ready_i=0, 16 pixels of value 3.
  - First word FFFF held stable in dat_o. Second word stored in the accumulator; pix_ready_o=0 from then on.
  - Raise dat_ready_i → FFFF, FFFF delivered in order on consecutive cycles, and pix_ready_o returns to 1.
- Reset mid-word: 8bpp pixel AB accepted, then reset_i pulse → all outputs at reset values. Then CD,EF → CDEF (AB is lost).
